// File: rtl/difftest_axis_packer.sv
// difftest_axis_packer: ping-pong buffers difftest frames and streams each one on AXI4-Stream as a header beat plus payload beats
module difftest_axis_packer #(
  parameter int DATA_W  = 512,
  parameter int FRAME_W = 4064
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [FRAME_W-1:0]  in_data,
  input  logic                in_enable,
  input  logic                in_step,
  input  logic                in_zeon,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                stall,
  output logic [31:0]         frame_cnt,
  output logic [15:0]         drop_cnt
);
  localparam int PAY_BEATS  = (FRAME_W + DATA_W - 1) / DATA_W;
  localparam int KB         = DATA_W / 8;
  localparam int LAST_BYTES = FRAME_W / 8 - (PAY_BEATS - 1) * KB;
  localparam int CW         = $clog2(PAY_BEATS);
  localparam int TOT        = PAY_BEATS * DATA_W;
  localparam logic [KB-1:0] ONES      = '1;
  localparam logic [KB-1:0] LAST_KEEP = ONES >> (KB - LAST_BYTES);
  localparam logic [CW-1:0] LAST      = CW'(PAY_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          rd_q, rd_d;
  logic [1:0]                    full_q, full_d;
  logic [31:0]                   frame_q;
  logic [15:0]                   drop_q;
  logic [FRAME_W-1:0]            data_q [2];
  logic [31:0]                   seq_q [2];
  logic [1:0]                    step_q, zeon_q;
  logic [DATA_W-1:0]             tdata_q, tdata_d;
  logic [KB-1:0]                 tkeep_q, tkeep_d;
  logic                          tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                          hs, fin, acc, widx;
  logic [PAY_BEATS-1:0][DATA_W-1:0] words;

  assign hs   = tvalid_q & m_axis_tready;
  assign fin  = hs & tlast_q;
  // A buffer freed by the final handshake is reusable in the same cycle when both are occupied
  assign acc  = in_enable & (~&full_q | fin);
  // Write slot trails the read pointer so drain order always equals acceptance order
  assign widx = (full_q[rd_q] & ~&full_q) ? ~rd_q : rd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      full_q   <= '0;
      frame_q  <= '0;
      drop_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      full_q   <= full_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      if (acc) frame_q <= frame_q + 32'd1;
      else if (in_enable && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (acc) begin
      data_q[widx] <= in_data;
      seq_q[widx]  <= frame_q;
      step_q[widx] <= in_step;
      zeon_q[widx] <= in_zeon;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    full_d  = full_q;
    case (state_q)
      IDLE: if (full_q[rd_q]) state_d = HDR;
      HDR: if (hs) begin
        state_d = PAY;
        cnt_d   = '0;
      end
      default: if (fin) begin
        state_d       = full_q[~rd_q] ? HDR : IDLE;
        rd_d          = ~rd_q;
        full_d[rd_q]  = 1'b0;
      end else if (hs) cnt_d = cnt_q + CW'(1);
    endcase
    if (acc) full_d[widx] = 1'b1;
  end

  // Output registers are loaded with the beat the next state will present
  always_comb begin
    words    = TOT'(data_q[rd_d]);
    tvalid_d = state_d != IDLE;
    tlast_d  = state_d == PAY && cnt_d == LAST;
    tkeep_d  = state_d == IDLE ? '0 : tlast_d ? LAST_KEEP : ONES;
    tdata_d  = state_d == HDR ? DATA_W'({zeon_q[rd_d], step_q[rd_d], seq_q[rd_d], 16'hD1F7}) :
               state_d == PAY ? words[cnt_d] : '0;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign stall         = &full_q;
  assign frame_cnt     = frame_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_difftest_axis_packer.sv
// tb_difftest_axis_packer: queue-based frame model checks the 512-bit packer every cycle; directed cases pin latency, drops and the 64-bit variant
module tb_difftest_axis_packer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [4063:0] in_data;
  logic          in_enable, in_step, in_zeon, tready, en64, tready64;
  logic [511:0]  tdata;
  logic [63:0]   tkeep;
  logic          tvalid, tlast, stall;
  logic [31:0]   fcnt;
  logic [15:0]   dcnt;
  logic [63:0]   tdata64;
  logic [7:0]    tkeep64;
  logic          tvalid64, tlast64, stall64;
  logic [31:0]   fcnt64;
  logic [15:0]   dcnt64;

  int errors = 0;
  int checks = 0;

  difftest_axis_packer #(.DATA_W(512), .FRAME_W(4064)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .in_step(in_step), .in_zeon(in_zeon), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .stall(stall), .frame_cnt(fcnt), .drop_cnt(dcnt));

  difftest_axis_packer #(.DATA_W(64), .FRAME_W(4064)) dut64 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(en64),
    .in_step(in_step), .in_zeon(in_zeon), .m_axis_tdata(tdata64), .m_axis_tkeep(tkeep64),
    .m_axis_tvalid(tvalid64), .m_axis_tready(tready64), .m_axis_tlast(tlast64),
    .stall(stall64), .frame_cnt(fcnt64), .drop_cnt(dcnt64));

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_beat(input logic [4063:0] d, input logic [31:0] s,
                                            input logic st, input logic ze, input int k);
    logic [4095:0] p;
    logic [511:0]  h;
    h = '0;
    h[15:0]  = 16'hD1F7;
    h[47:16] = s;
    h[48]    = st;
    h[49]    = ze;
    p = {32'b0, d};
    return k == 0 ? h : p[(k-1)*512 +: 512];
  endfunction

  // Model: frames held by the packer, in acceptance order, and the beat index of the head frame
  logic [4063:0] qd[$];
  logic [31:0]   qq[$];
  logic          qs[$], qz[$];
  int            m_beat, occ, idle;
  logic [31:0]   m_fc;
  logic [15:0]   m_dc;
  logic          fin, pv, pl;
  logic [511:0]  pd;
  logic [63:0]   pk;

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_tdata", tdata, '0);
      check("rst_ctl", {tvalid, tlast, stall, tkeep, fcnt, dcnt}, '0);
      qd.delete(); qq.delete(); qs.delete(); qz.delete();
      m_beat = 0; m_fc = '0; m_dc = '0; pv = 1'b0; idle = 0;
    end else begin
      check("stall", stall, qd.size() == 2);
      check("frame_cnt", fcnt, m_fc);
      check("drop_cnt", dcnt, m_dc);
      if (pv) begin
        check("hold_data", tdata, pd);
        check("hold_ctl", {tvalid, tlast, tkeep}, {1'b1, pl, pk});
      end
      if (qd.size() > 0 && !tvalid) idle++;
      else idle = 0;
      if (qd.size() > 0) check("valid_latency", idle <= 1, 1'b1);
      if (tvalid) begin
        if (qd.size() == 0) check("spurious_valid", tvalid, 1'b0);
        else begin
          check("tdata", tdata, exp_beat(qd[0], qq[0], qs[0], qz[0], m_beat));
          check("tkeep", tkeep, m_beat == 8 ? 64'h0FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
          check("tlast", tlast, m_beat == 8);
        end
      end
      pv = tvalid && !tready; pd = tdata; pk = tkeep; pl = tlast;
      occ = qd.size();
      fin = 1'b0;
      if (tvalid && tready && occ > 0) begin
        if (m_beat == 8) begin
          fin = 1'b1;
          m_beat = 0;
          void'(qd.pop_front()); void'(qq.pop_front());
          void'(qs.pop_front()); void'(qz.pop_front());
        end else m_beat++;
      end
      if (in_enable) begin
        if (occ < 2 || fin) begin
          qd.push_back(in_data); qq.push_back(m_fc);
          qs.push_back(in_step); qz.push_back(in_zeon);
          m_fc++;
        end else if (m_dc != 16'hFFFF) m_dc++;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_frame;
    for (int i = 0; i < 127; i++) in_data[i*32 +: 32] = $urandom;
  endtask

  logic [19:0]   vv, ll;
  logic [31:0]   s0, s9;
  logic [4095:0] p64;

  initial begin
    in_data = '0; in_enable = 0; in_step = 0; in_zeon = 0;
    tready = 0; en64 = 0; tready64 = 1;
    repeat (3) tick;
    check("init_valid", {tvalid, tvalid64}, 2'b00);
    reset = 1;
    tick;
    // single alternating-bit frame, DMA always ready
    tready = 1;
    for (int i = 0; i < 4064; i++) in_data[i] = i[0];
    in_enable = 1;
    tick;
    in_enable = 0;
    check("hdr_latency", tvalid, 1'b0);
    tick;
    check("hdr_valid", tvalid, 1'b1);
    check("hdr_word", tdata[63:0], 64'h0000_0000_0000_D1F7);
    for (int k = 1; k <= 8; k++) begin
      tick;
      check("t1_tlast", tlast, k == 8);
      if (k == 8) begin
        check("t1_keep", tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
        check("t1_last_data", tdata, {32'h0, {240{2'b10}}});
      end
    end
    tick;
    check("t1_after_last", tvalid, 1'b0);
    // backpressure: two frames buffered, third dropped
    reset = 0;
    tick;
    reset = 1;
    tick;
    tready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_frame;
      in_step = i[0];
      in_zeon = ~i[0];
      in_enable = 1;
      tick;
      in_enable = 0;
      tick;
    end
    repeat (34) tick;
    check("t2_stall", stall, 1'b1);
    check("t2_drop", dcnt, 16'd1);
    check("t2_frames", fcnt, 32'd2);
    tready = 1;
    for (int c = 0; c < 20; c++) begin
      vv[c] = tvalid;
      ll[c] = tlast;
      if (c == 0) s0 = tdata[47:16];
      if (c == 9) s9 = tdata[47:16];
      tick;
    end
    check("t2_b2b_valid", vv, 20'h3FFFF);
    check("t2_tlast_pos", ll, 20'h20100);
    check("t2_seq0", s0, 32'd0);
    check("t2_seq1", s9, 32'd1);
    // capture coinciding with the final handshake while both buffers are full
    tready = 0;
    for (int i = 0; i < 2; i++) begin
      rand_frame;
      in_enable = 1;
      tick;
      in_enable = 0;
      tick;
    end
    tick;
    check("t3_stall", stall, 1'b1);
    tready = 1;
    repeat (8) tick;
    check("t3_at_tlast", tlast, 1'b1);
    rand_frame;
    in_enable = 1;
    tick;
    in_enable = 0;
    check("t3_drop", dcnt, 16'd1);
    check("t3_frames", fcnt, 32'd5);
    check("t3_stall_again", stall, 1'b1);
    repeat (30) tick;
    // random 30% ready, a frame every 20 cycles
    for (int f = 0; f < 100; f++) begin
      rand_frame;
      in_step = 1'($urandom);
      in_zeon = 1'($urandom);
      in_enable = 1;
      for (int c = 0; c < 20; c++) begin
        tready = $urandom_range(0, 9) < 3;
        tick;
        in_enable = 0;
      end
    end
    tready = 1;
    repeat (40) tick;
    check("t4_drained_valid", tvalid, 1'b0);
    check("t4_drained_stall", stall, 1'b0);
    // 64-bit instance: 65 beats, 4-byte last beat
    rand_frame;
    in_step = 1;
    in_zeon = 0;
    p64 = {32'b0, in_data};
    en64 = 1;
    tick;
    en64 = 0;
    check("w64_hdr_latency", tvalid64, 1'b0);
    tick;
    check("w64_hdr", tdata64, {14'b0, 1'b0, 1'b1, 32'd0, 16'hD1F7});
    check("w64_hdr_keep", tkeep64, 8'hFF);
    for (int k = 1; k <= 64; k++) begin
      tick;
      check("w64_data", tdata64, p64[(k-1)*64 +: 64]);
      check("w64_tlast", tlast64, k == 64);
      if (k == 1) check("w64_keep_full", tkeep64, 8'hFF);
      if (k == 64) begin
        check("w64_keep_last", tkeep64, 8'h0F);
        check("w64_upper_zero", tdata64[63:32], 32'd0);
      end
    end
    tick;
    check("w64_done", {tvalid64, stall64, fcnt64, dcnt64}, {1'b0, 1'b0, 32'd1, 16'd0});
    // reset asserted while beat 4 is on the bus
    rand_frame;
    in_enable = 1;
    tick;
    in_enable = 0;
    tick;
    repeat (4) tick;
    check("t6_beat4_valid", tvalid, 1'b1);
    #2 reset = 0;
    #1;
    check("t6_valid_drop", tvalid, 1'b0);
    check("t6_counters", {fcnt, dcnt}, 48'd0);
    tick;
    reset = 1;
    tick;
    in_step = 0;
    in_zeon = 1;
    rand_frame;
    in_enable = 1;
    tick;
    in_enable = 0;
    tick;
    check("t6_new_hdr", tdata[63:0], {14'b0, 1'b1, 1'b0, 32'd0, 16'hD1F7});
    repeat (12) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
